// File: rtl/eth_csr_axil_master.sv
// eth_csr_axil_master: AXI4-Lite initiator driving the Ethernet CSR slave from a
// valid/ready command/response port. Optional watchdog: define ETH_CSR_MASTER_TIMEOUT_EN.
module eth_csr_axil_master #(
  parameter int unsigned         ADDR_WIDTH     = 32,
  parameter int unsigned         DATA_WIDTH     = 32,
  parameter int unsigned         ID_WIDTH       = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID         = '0,
  parameter int unsigned         TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_A,
    RD_R,
    RSP
`ifdef ETH_CSR_MASTER_TIMEOUT_EN
    , DRAIN
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic                    bready_q, bready_d;
  logic                    rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

  // IDs are fixed, so returned IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{m_bid, m_rid};

`ifdef ETH_CSR_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             drain_q, drain_d;
  logic             wr_q, wr_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef ETH_CSR_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
    drain_d       = drain_q;
    wr_d          = wr_q;

    // After a timeout the abandoned transaction keeps running in the background
    // (through RSP and DRAIN) so every valid still completes its handshake.
    if ((state_q == RSP || state_q == DRAIN) && drain_q) begin
      if (awvalid_q && m_awready) awvalid_d = 1'b0;
      if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
      if (arvalid_q && m_arready) arvalid_d = 1'b0;
      if (wr_q) begin
        if (!awvalid_d && !wvalid_d) bready_d = 1'b1;
        if (bready_q && m_bvalid) begin
          bready_d = 1'b0;
          drain_d  = 1'b0;
        end
      end else begin
        if (!arvalid_d) rready_d = 1'b1;
        if (rready_q && m_rvalid) begin
          rready_d = 1'b0;
          drain_d  = 1'b0;
        end
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
`ifdef ETH_CSR_MASTER_TIMEOUT_EN
          wr_d        = cmd_write;
`endif
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_A;
          end
        end
      end
      WR: begin
        if (awvalid_q && m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (m_bvalid) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_A: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (m_rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_rdata;
          rsp_resp_d  = m_rresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef ETH_CSR_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
          if (drain_d) begin
            state_d = DRAIN;
          end else begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end
`else
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
`endif
        end
      end
`ifdef ETH_CSR_MASTER_TIMEOUT_EN
      DRAIN: begin
        if (!drain_d) begin
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef ETH_CSR_MASTER_TIMEOUT_EN
    // The counter restarts on every phase change; expiry overrides a stalled phase.
    if (state_q == WR || state_q == WR_B || state_q == RD_A || state_q == RD_R) begin
      if (state_d != state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        cnt_d         = '0;
        state_d       = RSP;
        rsp_valid_d   = 1'b1;
        rsp_resp_d    = 2'b10;
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b1;
        drain_d       = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef ETH_CSR_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
      drain_q       <= 1'b0;
      wr_q          <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
      drain_q       <= drain_d;
      wr_q          <= wr_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign m_awid    = AXI_ID;
  assign m_awaddr  = addr_q;
  assign m_awprot  = 3'b000;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_arid    = AXI_ID;
  assign m_araddr  = addr_q;
  assign m_arprot  = 3'b000;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

endmodule

// File: tb/tb_eth_csr_axil_master.sv
// Directed bench for eth_csr_axil_master: write, read, skewed write, error with
// backpressure, reset mid-write and (with ETH_CSR_MASTER_TIMEOUT_EN) watchdog.
module tb_eth_csr_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  m_awid, m_arid, m_bid, m_rid;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int errors = 0;
  int checks = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_hs = 0;

  eth_csr_axil_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .AXI_ID(4'h0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      if (m_awvalid && m_awready) aw_hs++;
      if (m_wvalid && m_wready)   w_hs++;
      if (m_bvalid && m_bready)   b_hs++;
      if (m_arvalid && m_arready) ar_hs++;
      if (m_rvalid && m_rready)   r_hs++;
      if (rsp_valid && rsp_ready) rsp_hs++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  // Returns at the negedge after the accepting posedge.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cmd_ready=%b rsp_valid=%b rsp_timeout=%b expected 1 0 0",
               cmd_ready, rsp_valid, rsp_timeout);
    end
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_axi: aw=%b w=%b ar=%b b=%b r=%b expected all 0",
               m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready);
    end
    checks++;
    if (m_awaddr !== 32'h0 || m_wdata !== 32'h0 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
      errors++;
      $display("FAIL reset_data: awaddr=%h wdata=%h rdata=%h resp=%b expected zeros",
               m_awaddr, m_wdata, rsp_rdata, rsp_resp);
    end
    checks++;
    if (m_awprot !== 3'b000 || m_arprot !== 3'b000 || m_awid !== 4'h0 || m_arid !== 4'h0) begin
      errors++;
      $display("FAIL fixed_fields: awprot=%b arprot=%b awid=%h arid=%h expected 0",
               m_awprot, m_arprot, m_awid, m_arid);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write();
    int aw0, w0, b0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    m_awready = 1'b1; m_wready = 1'b1; m_bresp = 2'b00;
    send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_issue: awvalid=%b wvalid=%b cmd_ready=%b expected 1 1 0",
               m_awvalid, m_wvalid, cmd_ready);
    end
    checks++;
    if (m_awaddr !== 32'h10 || m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL write_payload: addr=%h data=%h strb=%h expected 00000010 deadbeef f",
               m_awaddr, m_wdata, m_wstrb);
    end
    @(negedge clk);
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b1) begin
      errors++;
      $display("FAIL write_bready: awvalid=%b wvalid=%b bready=%b expected 0 0 1",
               m_awvalid, m_wvalid, m_bready);
    end
    m_bvalid = 1'b1;
    @(negedge clk);
    m_bvalid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || m_bready !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp: valid=%b resp=%b rdata=%h bready=%b expected 1 00 0 0",
               rsp_valid, rsp_resp, rsp_rdata, m_bready);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_done: rsp_valid=%b cmd_ready=%b expected 0 1", rsp_valid, cmd_ready);
    end
    checks++;
    if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
      errors++;
      $display("FAIL write_hs_count: aw=%0d w=%0d b=%0d expected 1 1 1",
               aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
  endtask

  task automatic test_read();
    int ar0;
    ar0 = ar_hs;
    m_arready = 1'b1; m_rvalid = 1'b0;
    send_cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h4 || m_awvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_issue: arvalid=%b araddr=%h awvalid=%b expected 1 4 0",
               m_arvalid, m_araddr, m_awvalid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (m_rready !== 1'b1 || m_arvalid !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL read_wait%0d: rready=%b arvalid=%b rsp_valid=%b expected 1 0 0",
                 i, m_rready, m_arvalid, rsp_valid);
      end
    end
    m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_rresp = 2'b00;
    @(negedge clk);
    m_rvalid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_resp !== 2'b00 || m_rready !== 1'b0) begin
      errors++;
      $display("FAIL read_rsp: valid=%b rdata=%h resp=%b rready=%b expected 1 12345678 00 0",
               rsp_valid, rsp_rdata, rsp_resp, m_rready);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (ar_hs - ar0 != 1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_ar_count: ar=%0d cmd_ready=%b expected 1 1", ar_hs - ar0, cmd_ready);
    end
  endtask

  task automatic test_skewed_write();
    for (int v = 0; v < 2; v++) begin
      int b0;
      b0 = b_hs;
      m_awready = (v == 1); m_wready = (v == 0); m_bresp = 2'b00;
      send_cmd(1'b1, 32'h0000_0020 + v, 32'hA5A5_0000 + v, 4'h3);
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        checks++;
        if ((v == 0 ? m_awvalid : m_wvalid) !== 1'b1 || m_bready !== 1'b0 ||
            m_awaddr !== 32'h20 + v || m_wdata !== 32'hA5A5_0000 + v || m_wstrb !== 4'h3) begin
          errors++;
          $display("FAIL skew%0d_hold%0d: awv=%b wv=%b bready=%b addr=%h data=%h expected held",
                   v, i, m_awvalid, m_wvalid, m_bready, m_awaddr, m_wdata);
        end
      end
      // B is offered before bready rises.
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL skew%0d_bready: awv=%b wv=%b bready=%b rsp_valid=%b expected 0 0 1 0",
                 v, m_awvalid, m_wvalid, m_bready, rsp_valid);
      end
      @(negedge clk);
      m_bvalid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || b_hs - b0 != 1) begin
        errors++;
        $display("FAIL skew%0d_rsp: rsp_valid=%b b_hs=%0d expected 1 1", v, rsp_valid, b_hs - b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_error_backpressure();
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b10;
    send_cmd(1'b1, 32'h0000_0030, 32'h0000_0001, 4'h1);
    @(negedge clk);
    @(negedge clk);
    m_bvalid = 1'b0; m_bresp = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || cmd_ready !== 1'b0 || m_arvalid !== 1'b0) begin
        errors++;
        $display("FAIL err_stall%0d: valid=%b resp=%b cmd_ready=%b arvalid=%b expected 1 10 0 0",
                 i, rsp_valid, rsp_resp, cmd_ready, m_arvalid);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_release: rsp_valid=%b cmd_ready=%b arvalid=%b expected 0 1 0",
               rsp_valid, cmd_ready, m_arvalid);
    end
  endtask

  task automatic test_reset_mid_write();
    int rsp0;
    m_awready = 1'b0; m_wready = 1'b0;
    send_cmd(1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'hF);
    rsp0 = rsp_hs;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid} !== 6'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: awv=%b wv=%b rsp_valid=%b cmd_ready=%b expected 0 0 0 1",
               m_awvalid, m_wvalid, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001; m_rresp = 2'b00;
    send_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (m_rready !== 1'b1 || m_awvalid !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_rready: rready=%b awvalid=%b rsp_valid=%b expected 1 0 0",
               m_rready, m_awvalid, rsp_valid);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0001 || rsp_hs != rsp0) begin
      errors++;
      $display("FAIL midreset_read: valid=%b rdata=%h extra_rsp=%0d expected 1 cafe0001 0",
               rsp_valid, rsp_rdata, rsp_hs - rsp0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

`ifdef ETH_CSR_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int rsp0, r0;
    m_arready = 1'b1; m_rvalid = 1'b0;
    send_cmd(1'b0, 32'h0000_0060, 32'h0, 4'h0);
    @(negedge clk);
    rsp0 = rsp_hs; r0 = r_hs;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || m_rready !== 1'b1) begin
        errors++;
        $display("FAIL tmo_wait%0d: rsp_valid=%b rready=%b expected 0 1", i, rsp_valid, m_rready);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL tmo_rsp: valid=%b timeout=%b resp=%b rdata=%h expected 1 1 10 0",
               rsp_valid, rsp_timeout, rsp_resp, rsp_rdata);
    end
    m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    m_rvalid = 1'b0;
    checks++;
    if (r_hs - r0 != 1 || m_rready !== 1'b0 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL tmo_drain: r_hs=%0d rready=%b rdata=%h cmd_ready=%b expected 1 0 0 0",
               r_hs - r0, m_rready, rsp_rdata, cmd_ready);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_hs - rsp0 != 1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_single: rsp_hs=%0d valid=%b cmd_ready=%b timeout=%b expected 1 0 1 0",
               rsp_hs - rsp0, rsp_valid, cmd_ready, rsp_timeout);
    end
  endtask
`endif

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bresp = '0; m_bid = 4'h5;
    m_rvalid = 1'b0; m_rresp = '0; m_rdata = '0; m_rid = 4'hA;
    test_reset();
    test_write();
    test_read();
    test_skewed_write();
    test_error_backpressure();
    test_reset_mid_write();
`ifdef ETH_CSR_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_csr_axil_master.md
Name: eth_csr_axil_master

Overview:
- AXI4-Lite initiator that drives the Ethernet CSR AXI4-Lite slave port from a simple valid/ready command/response interface.
- Lets a sequencer, boot FSM or bench program and poll the MAC CSRs without hand-driving AXI channels.
- One transaction outstanding at a time: either a write (AW+W, then B) or a read (AR, then R).
- Sits between the control agent and the ethernet_wrapper CSR slave.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width
DATA_WIDTH, 32, AXI-Lite data width; strobe width is DATA_WIDTH/8
AXI_ID, 0, constant value driven on awid/arid
TIMEOUT_CYCLES, 1024, response watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target CSR address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  bresp/rresp, or 2'b10 on timeout
rsp_timeout  out  1  response produced by watchdog
m_awid/m_awaddr/m_awprot/m_awvalid  out  IDW/ADDR_WIDTH/3/1  write address channel
m_awready  in  1  write address ready
m_wdata/m_wstrb/m_wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
m_wready  in  1  write data ready
m_bid/m_bresp/m_bvalid  in  IDW/2/1  write response channel
m_bready  out  1  write response ready
m_arid/m_araddr/m_arprot/m_arvalid  out  IDW/ADDR_WIDTH/3/1  read address channel
m_arready  in  1  read address ready
m_rid/m_rdata/m_rresp/m_rvalid  in  IDW/DATA_WIDTH/2/1  read data channel
m_rready  out  1  read data ready

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- All outputs are registered.
- Reset values: state=IDLE, cmd_ready=1, all m_*valid=0, m_bready=0, m_rready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, address/data registers=0.
- Fixed outputs: m_awprot and m_arprot are 3'b000; m_awid and m_arid equal AXI_ID; bid/rid are ignored.

FSM states:
- IDLE: cmd_ready=1.
  - On cmd_valid&cmd_ready, latch addr/wdata/wstrb and clear cmd_ready.
  - Write goes to WR; m_awvalid=m_wvalid=1 from the next cycle (1-cycle latency).
  - Read goes to RD_A; m_arvalid=1 from the next cycle.
- WR: AW and W complete independently.
  - Drop m_awvalid on the AW handshake and m_wvalid on the W handshake.
  - Both may handshake in the same cycle, in either order, or separated by any number of cycles.
  - When both are done, go to WR_B with m_bready=1.
- WR_B: on m_bvalid, capture bresp, set rsp_rdata=0, drop m_bready, go to RSP.
- RD_A: on m_arready, drop m_arvalid, set m_rready=1, go to RD_R.
- RD_R: on m_rvalid, capture rdata and rresp, drop m_rready, go to RSP.
- RSP: rsp_valid=1, with data and resp held stable until rsp_ready.
  - On rsp_valid&rsp_ready, clear rsp_valid, set cmd_ready=1, go to IDLE.
  - The earliest next command is the cycle after the response handshake.

AXI rules:
- A valid, once asserted, is never deasserted and its payload never changes until the handshake.
- No combinational path from any input to any output.

Boundary cases:
- rsp_ready low indefinitely: the block stalls in RSP and accepts no command.
- bvalid/rvalid already high when m_bready/m_rready rises: handshake completes that cycle.
- Reset mid-transaction: all channels deassert immediately (asynchronous). The in-flight transaction is abandoned and no response is produced.

Optional Feature:
ETH_CSR_MASTER_TIMEOUT_EN
- Defined:
  - A counter starts at 0 on entry to WR, RD_A, WR_B or RD_R.
  - If it reaches TIMEOUT_CYCLES before the phase completes, go to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - Pending valids are held until their handshake; the late B/R is then accepted and discarded in a DRAIN state.
  - cmd_ready stays 0 until DRAIN finishes and the response has been consumed.
- Undefined: no counter, no DRAIN state; rsp_timeout is tied to 0 and the block waits forever.

Test Plan:
- Write: cmd addr=0x0000_0010, wdata=0xDEAD_BEEF, wstrb=0xF; slave ready at once, bresp=0 -> AW/W handshake in cycle N+1, single B, rsp_valid with rsp_resp=0, rsp_rdata=0.
- Read: addr=0x0000_0004; slave returns rdata=0x1234_5678, rresp=0 after 5 cycles -> rsp_rdata=0x1234_5678, rsp_resp=0, exactly one AR handshake.
- Skewed write: awready delayed 7 cycles, wready immediate (then the reverse) -> payload held stable while waiting, m_bready rises only after both handshakes, single response.
- Error and backpressure: bresp=2'b10 with rsp_ready low for 10 cycles -> rsp_resp=2'b10 held stable for all 10 cycles, cmd_ready=0 until the response handshake.
- Timeout (macro on, TIMEOUT_CYCLES=16): rvalid never arrives -> rsp_timeout=1 and rsp_resp=2'b10 after 16 cycles in RD_R; a late rvalid is absorbed with no second rsp_valid.
- Reset mid-write (awvalid high, rst pulled low) -> all valids 0 and cmd_ready=1 after release; the next read completes normally.
